// File: rtl/button_event_encoder.sv
// button_event_encoder: debounce seven buttons and encode presses into a one-entry command register
//   clk        system clock, all state on its rising edge
//   reset_n    asynchronous active-low reset
//   btn_in     raw asynchronous buttons, active-high
//   btn_level  debounced button levels
//   cmd_code   0 none, else pressed button index + 1
//   cmd_valid  cmd_code holds a pending command, accepted with cmd_ready
//   drop_flag  sticky, set when an event is discarded; drop_clr clears it
// Define BUTTON_AUTO_REPEAT_EN to add the hold/auto-repeat FSM for codes 1-4.
module button_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 12_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] btn_in,
  output logic [2:0] cmd_code,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [6:0] btn_level,
  output logic       drop_flag,
  input  logic       drop_clr
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  logic [6:0] sync1, sync2, level_q, press;
  logic [DW-1:0] db_cnt [7];
  logic [2:0] win, rep_code, evt_code;
  logic multi, rep_evt, evt, drop;
  // a counter only runs while the synchronized input disagrees with the level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level_q <= '0;
      btn_level <= '0;
      for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      level_q <= btn_level;
      for (int i = 0; i < 7; i++)
        if (sync2[i] == btn_level[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DMAX) begin
          btn_level[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
    end
  assign press = btn_level & ~level_q;
  always_comb begin
    win = '0;
    for (int i = 0; i < 7; i++) if (press[i]) win = 3'(i);
  end
  assign multi = |(press & (press - 7'd1));
  assign evt = (|press) | rep_evt;
  assign evt_code = (|press) ? win + 3'd1 : rep_code;
  assign drop = multi | (evt & cmd_valid & ~cmd_ready);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cmd_valid <= 1'b0;
      cmd_code <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (evt && (!cmd_valid || cmd_ready)) begin
        cmd_valid <= 1'b1;
        cmd_code <= evt_code;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
        cmd_code <= '0;
      end
      drop_flag <= drop | (drop_flag & ~drop_clr);
    end
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t state;
  logic [2:0] lat;
  logic [RW-1:0] rcnt;
  logic rep_due;
  assign rep_due = (state == HOLD) ? rcnt == RW'(REPEAT_DELAY - 1) : (state == REPEAT) && rcnt == RW'(REPEAT_PERIOD - 1);
  // any fresh press pre-empts a repeat and restarts the FSM
  assign rep_evt = rep_due & btn_level[lat] & ~(|press);
  assign rep_code = lat + 3'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      lat <= '0;
      rcnt <= '0;
    end else if (|press) begin
      state <= (win < 3'd4) ? HOLD : IDLE;
      lat <= win;
      rcnt <= '0;
    end else if (state != IDLE) begin
      if (!btn_level[lat]) state <= IDLE;
      else if (rep_due) begin
        state <= REPEAT;
        rcnt <= '0;
      end else rcnt <= rcnt + 1'b1;
    end
`else
  assign rep_evt = 1'b0;
  assign rep_code = 3'd0;
`endif
endmodule

// File: tb/tb_button_event_encoder.sv
// tb_button_event_encoder: directed and randomized checks of button_event_encoder against a behavioural model
module tb_button_event_encoder;
  localparam int D = 4;
  localparam int RD = 16;
  localparam int RP = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] btn_in = '0;
  logic cmd_ready = 1'b0;
  logic drop_clr = 1'b0;
  logic [2:0] cmd_code;
  logic cmd_valid;
  logic [6:0] btn_level;
  logic drop_flag;
  int errors = 0;
  int checks = 0;

  button_event_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .cmd_code(cmd_code), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .btn_level(btn_level), .drop_flag(drop_flag), .drop_clr(drop_clr));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: a level flips once the last D synchronized samples (input seen two edges late)
  // all disagree with it; repeats fire at hold ages RD-1, RD-1+RP, ... counted from the press load.
  logic [6:0] hist [0:D+1];
  logic [6:0] m_level, m_press, m_nl;
  logic m_valid, m_drop, m_rep, m_ev, m_drp, m_all;
  logic [2:0] m_code;
  bit r_act;
  int r_btn, r_age, m_w;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= D + 1; j++) hist[j] = '0;
      m_level = '0; m_press = '0; m_valid = 0; m_code = '0; m_drop = 0;
      r_act = 0; r_btn = 0; r_age = 0;
    end else begin
      m_w = -1;
      for (int i = 0; i < 7; i++) if (m_press[i]) m_w = i;
`ifdef BUTTON_AUTO_REPEAT_EN
      m_rep = r_act && m_level[r_btn] && m_press == 0 && r_age >= RD - 1 && (r_age - (RD - 1)) % RP == 0;
`else
      m_rep = 0;
`endif
      m_ev = (m_w >= 0) || m_rep;
      m_drp = ($countones(m_press) > 1) || (m_ev && m_valid && !cmd_ready);
      if (m_ev && (!m_valid || cmd_ready)) begin
        m_valid = 1;
        m_code = 3'((m_w >= 0 ? m_w : r_btn) + 1);
      end else if (cmd_ready) begin
        m_valid = 0;
        m_code = 0;
      end
      m_drop = m_drp || (m_drop && !drop_clr);
      if (m_w >= 0) begin
        r_act = m_w <= 3; r_btn = m_w; r_age = 0;
      end else if (r_act && !m_level[r_btn]) r_act = 0;
      else r_age++;
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btn_in;
      m_nl = m_level;
      for (int i = 0; i < 7; i++) begin
        m_all = 1;
        for (int j = 2; j <= D + 1; j++) if (hist[j][i] == m_level[i]) m_all = 0;
        if (m_all) m_nl[i] = ~m_level[i];
      end
      m_press = m_nl & ~m_level;
      m_level = m_nl;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (cmd_code !== 3'd0) begin errors++; $display("FAIL reset cmd_code: got %0d want 0", cmd_code); end
    checks++; if (btn_level !== 7'd0) begin errors++; $display("FAIL reset btn_level: got %b want 0", btn_level); end
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL reset drop_flag: got %b want 0", drop_flag); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_press();
    int c;
    btn_in = 7'b0001000;
    cmd_ready = 1'b0;
    for (c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (btn_level[3]) break;
    end
    checks++; if (c != 6) begin errors++; $display("FAIL press latency: level rose after %0d cycles want 6", c); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL press early valid: got %b want 0", cmd_valid); end
    @(negedge clk);
    checks++; if ({cmd_valid, cmd_code} !== {1'b1, 3'd4}) begin errors++; $display("FAIL press cmd: got v=%b code=%0d want v=1 code=4", cmd_valid, cmd_code); end
    cmd_ready = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_valid, cmd_code} !== {1'b0, 3'd0}) begin errors++; $display("FAIL press accept: got v=%b code=%0d want v=0 code=0", cmd_valid, cmd_code); end
    btn_in = '0;
    repeat (10) @(negedge clk);
    checks++; if ({cmd_valid, btn_level} !== 8'd0) begin errors++; $display("FAIL release no event: got v=%b lvl=%b want 0", cmd_valid, btn_level); end
  endtask

  task automatic test_bounce();
    int bad = 0;
    for (int c = 0; c < 20; c++) begin
      btn_in[4] = c[1] ? 1'b0 : 1'b1;
      @(negedge clk);
      if (btn_level !== 7'd0 || cmd_valid !== 1'b0) bad++;
    end
    btn_in = '0;
    repeat (8) @(negedge clk);
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce: %0d cycles with level/valid set, want 0", bad); end
    checks++; if ({cmd_valid, btn_level} !== 8'd0) begin errors++; $display("FAIL bounce settle: got v=%b lvl=%b want 0", cmd_valid, btn_level); end
  endtask

  task automatic test_simultaneous();
    int c;
    cmd_ready = 1'b1;
    btn_in = 7'b1000001;
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cmd_valid) break;
    end
    checks++; if (c != 7) begin errors++; $display("FAIL simul latency: valid after %0d cycles want 7", c); end
    checks++; if (cmd_code !== 3'd7) begin errors++; $display("FAIL simul code: got %0d want 7", cmd_code); end
    checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL simul drop: got %b want 1", drop_flag); end
    @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL simul single event: got v=%b want 0", cmd_valid); end
    drop_clr = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0;
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL drop_clr: got %b want 0", drop_flag); end
    btn_in = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_hold();
    int t[$];
    int e[$];
    int bad = 0;
`ifdef BUTTON_AUTO_REPEAT_EN
    e = '{7, 7 + RD, 7 + RD + RP, 7 + RD + 2 * RP};
`else
    e = '{7};
`endif
    cmd_ready = 1'b1;
    btn_in = 7'b0000010;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (cmd_valid) begin
        t.push_back(c);
        if (cmd_code !== 3'd2) bad++;
      end
      if (c == 40) btn_in = '0;
    end
    checks++; if (t.size() != e.size()) begin errors++; $display("FAIL hold count: got %0d events want %0d", t.size(), e.size()); end
    for (int i = 0; i < e.size() && i < t.size(); i++) begin
      checks++; if (t[i] != e[i]) begin errors++; $display("FAIL hold event %0d: at cycle %0d want %0d", i, t[i], e[i]); end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold code: %0d events with code != 2", bad); end
  endtask

  task automatic test_busy_reset();
    int c;
    int seen = 0;
    cmd_ready = 1'b0;
    btn_in = 7'b0010000;
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cmd_valid) break;
    end
    checks++; if ({cmd_valid, cmd_code} !== {1'b1, 3'd5}) begin errors++; $display("FAIL busy load: got v=%b code=%0d want v=1 code=5", cmd_valid, cmd_code); end
    btn_in = '0;
    repeat (8) @(negedge clk);
    drop_clr = 1'b1;
    btn_in = 7'b0000100;
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (btn_level[2]) break;
    end
    @(negedge clk);
    drop_clr = 1'b0;
    checks++; if ({cmd_valid, cmd_code} !== {1'b1, 3'd5}) begin errors++; $display("FAIL busy hold: got v=%b code=%0d want v=1 code=5", cmd_valid, cmd_code); end
    checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL busy drop with clr: got %b want 1", drop_flag); end
    btn_in = '0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({cmd_valid, cmd_code, btn_level, drop_flag} !== 12'd0) begin errors++; $display("FAIL async reset: got v=%b code=%0d lvl=%b drop=%b want 0", cmd_valid, cmd_code, btn_level, drop_flag); end
    @(negedge clk);
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    for (c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cmd_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL post reset event: %0d valid cycles want 0", seen); end
    btn_in = 7'b0100000;
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cmd_valid) break;
    end
    checks++; if (c != 7 || cmd_code !== 3'd6) begin errors++; $display("FAIL post reset press: after %0d cycles code %0d want 7 cycles code 6", c, cmd_code); end
    btn_in = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    logic [6:0] cur = btn_in;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if ({cmd_valid, cmd_code, btn_level, drop_flag} !== {m_valid, m_code, m_level, m_drop}) begin
        errors++;
        $display("FAIL random cycle %0d: got v=%b code=%0d lvl=%b drop=%b want v=%b code=%0d lvl=%b drop=%b",
                 c, cmd_valid, cmd_code, btn_level, drop_flag, m_valid, m_code, m_level, m_drop);
      end
      for (int i = 0; i < 7; i++) if ($urandom_range(c < 1500 ? 5 : 40) == 0) cur[i] = ~cur[i];
      btn_in = cur;
      cmd_ready = $urandom_range(3) != 0;
      drop_clr = $urandom_range(15) == 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_hold();
    test_busy_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_event_encoder.md
BUTTON_EVENT_ENCODER -- requirements
Module: button_event_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, number of consecutive stable synchronized samples that updates a debounced level.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25_000_000, number of hold cycles before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 12_500_000, number of cycles between later auto-repeats.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 btn_in  input  7  raw asynchronous buttons, active-high; [0] right, [1] left, [2] down, [3] up, [4] decision, [5] red reset, [6] blue reset.
REQ-007 cmd_code  output  3  command code: 0 none, else (button index + 1), 1..7.
REQ-008 cmd_valid  output  1  cmd_code holds a pending command.
REQ-009 cmd_ready  input  1  consumer accepts the command when high together with cmd_valid.
REQ-010 btn_level  output  7  debounced button levels.
REQ-011 drop_flag  output  1  sticky; set when an event is discarded.
REQ-012 drop_clr  input  1  synchronous clear of drop_flag.

Function
REQ-013 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each bit SHALL have its own debounce counter; it restarts whenever the synchronized value differs from btn_level.
REQ-015 btn_level[i] SHALL take the synchronized value on the cycle its counter reaches DEBOUNCE_CYCLES-1 with the input still differing.
REQ-016 A press event SHALL be a 0->1 transition of btn_level[i]; releases SHALL generate no event.
REQ-017 When press events occur in the same cycle, the highest index SHALL win; the others SHALL be discarded and set drop_flag.
REQ-018 An event SHALL load the one-entry output register the cycle after the btn_level rise (cmd_valid high, cmd_code = index+1), provided the register is empty or is being accepted that same cycle.
REQ-019 An event arriving while cmd_valid=1 and cmd_ready=0 SHALL be discarded and set drop_flag; the held command SHALL be unchanged.
REQ-020 cmd_code SHALL be stable while cmd_valid=1 and cmd_ready=0; on acceptance with no new event, cmd_valid SHALL drop next cycle and cmd_code SHALL become 0.
REQ-021 The repeat FSM SHALL have three states: IDLE, HOLD, REPEAT.
REQ-022 IDLE->HOLD: on a press event for codes 1-4, latching that button; the hold counter clears.
REQ-023 HOLD->REPEAT: after REPEAT_DELAY cycles with the latched level still high; this emits a repeat event.
REQ-024 REPEAT: SHALL emit a repeat event every REPEAT_PERIOD cycles.
REQ-025 Any state->IDLE when the latched btn_level falls or when any other button's press event occurs; the new press, if codes 1-4, immediately re-enters HOLD.
REQ-026 Repeat events SHALL obey the REQ-018/REQ-019 rules, and their counters SHALL wrap without saturating.
REQ-027 drop_clr together with a new drop in the same cycle SHALL leave drop_flag=1.

Reset
REQ-028 On reset_n low, immediately: cmd_valid=0, cmd_code=0, btn_level=0, drop_flag=0, FSM=IDLE, all counters and synchronizers 0.
REQ-029 Reset mid-hold or mid-handshake SHALL discard the pending command with no event on release of reset.
REQ-030 The first events after reset deassertion SHALL require full debounce from zero levels.

Configuration
REQ-031 Macro BUTTON_AUTO_REPEAT_EN defined: the REQ-021..REQ-026 repeat FSM is present.
REQ-032 Macro BUTTON_AUTO_REPEAT_EN undefined: no repeat FSM or counters; held buttons produce exactly one event per press; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8)
REQ-033 Press btn_in[3] steady -> btn_level[3] rises within 2+4 cycles; next cycle cmd_valid=1, cmd_code=4; cmd_ready=1 -> cmd_valid=0 next cycle.
REQ-034 Toggle btn_in[4] every 2 cycles for 20 cycles -> no btn_level change, no cmd_valid.
REQ-035 btn_in[0] and btn_in[6] rise together -> single cmd_code=7, drop_flag=1; drop_clr -> drop_flag=0.
REQ-036 Hold btn_in[1] 40 cycles with cmd_ready=1 (macro defined) -> codes 2 at press, press+16, press+24, press+32; with macro undefined -> one event only.
REQ-037 cmd_ready=0 with code 5 pending, then press btn_in[2] -> cmd_code stays 5, drop_flag=1.
REQ-038 Assert reset_n=0 while cmd_valid=1 -> outputs zero asynchronously; no event after release until a new debounced press.
